// File: rtl/rv64i_pkg.sv
// rv64i_pkg: opcodes, funct3 encodings, ALU/immediate enums and decode helpers for the RV64I core
package rv64i_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
  localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_LB   = 3'd0, F3_LH  = 3'd1, F3_LW  = 3'd2, F3_LD   = 3'd3;
  localparam logic [2:0] F3_LBU  = 3'd4, F3_LHU = 3'd5, F3_LWU = 3'd6;
  localparam logic [2:0] F3_SB   = 3'd0, F3_SH  = 3'd1, F3_SW  = 3'd2, F3_SD   = 3'd3;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
  function automatic logic [63:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] i);
    case (fmt)
      IMM_S:   gen_imm = {{52{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   gen_imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   gen_imm = {{32{i[31]}}, i[31:12], 12'b0};
      IMM_J:   gen_imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: gen_imm = {{52{i[31]}}, i[31:20]};
    endcase
  endfunction
  function automatic alu_op_e f3_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  f3_alu = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  f3_alu = ALU_SLL;
      F3_SLT:  f3_alu = ALU_SLT;
      F3_SLTU: f3_alu = ALU_SLTU;
      F3_XOR:  f3_alu = ALU_XOR;
      F3_SR:   f3_alu = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/rv64i_regfile.sv
// rv64i_regfile: 32x64 register file, two combinational reads, one write, x0 hardwired to zero
module rv64i_regfile
  import rv64i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [63:0] wd,
  output logic [63:0] rd1,
  output logic [63:0] rd2
);
  logic [63:0] regs_q [32];
  logic [63:0] regs_d [32];
  always_comb begin
    regs_d = regs_q;
    if (we && wa != 5'd0) regs_d[wa] = wd;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) regs_q[i] <= rst ? 64'd0 : regs_d[i];
  end
  assign rd1 = ra1 == 5'd0 ? 64'd0 : regs_q[ra1];
  assign rd2 = ra2 == 5'd0 ? 64'd0 : regs_q[ra2];
endmodule

// File: rtl/rv64i_single_cycle_core.sv
// rv64i_single_cycle_core: single-cycle RV64I core with external instruction bus and doubleword data port
module rv64i_single_cycle_core
  import rv64i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] addr,
  output logic        wr_en,
  output logic [63:0] wdata,
  output logic [7:0]  wmask,
  input  logic [63:0] rdata
);
  logic [6:0]  opcode, f7;
  logic [2:0]  f3, off;
  logic [4:0]  rd, rs1, rs2;
  logic [1:0]  size;
  logic [31:0] pc_q, pc_d, pc_plus4, imm_ls;
  logic [63:0] rs1_v, rs2_v, imm, alu_a, alu_b, alu_y, lsh, load_v, wb;
  logic [7:0]  mask_raw;
  logic        a_pc, a_zero, b_imm, reg_wr, is_load, is_store, is_branch, is_jal, is_jalr;
  logic        eq, lt, ltu, taken;
  imm_fmt_e    imm_fmt;
  alu_op_e     alu_op;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign f7     = inst[31:25];
  rv64i_regfile u_rf (
    .clk(clk), .rst(rst), .ra1(rs1), .ra2(rs2),
    .we(reg_wr & ~rst), .wa(rd), .wd(wb), .rd1(rs1_v), .rd2(rs2_v)
  );
  // Anything not explicitly recognised leaves every enable low and so retires as a NOP.
  always_comb begin
    imm_fmt   = IMM_I;
    alu_op    = ALU_ADD;
    a_pc      = 1'b0;
    a_zero    = 1'b0;
    b_imm     = 1'b1;
    reg_wr    = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OPC_OP: begin
        reg_wr = f7 == 7'h00 || (f7 == 7'h20 && (f3 == F3_ADD || f3 == F3_SR));
        b_imm  = 1'b0;
        alu_op = f3_alu(f3, inst[30]);
      end
      OPC_OP_IMM: begin
        reg_wr = f3 == F3_SLL ? inst[31:26] == 6'h00 :
                 f3 == F3_SR  ? (inst[31:26] == 6'h00 || inst[31:26] == 6'h10) : 1'b1;
        alu_op = f3_alu(f3, f3 == F3_SR && inst[30]);
      end
      OPC_LOAD: begin
        reg_wr  = f3 != 3'd7;
        is_load = f3 != 3'd7;
      end
      OPC_STORE: begin
        is_store = ~f3[2];
        imm_fmt  = IMM_S;
      end
      OPC_BRANCH: begin
        is_branch = f3[2:1] != 2'b01;
        imm_fmt   = IMM_B;
      end
      OPC_JAL: begin
        reg_wr  = 1'b1;
        is_jal  = 1'b1;
        imm_fmt = IMM_J;
      end
      OPC_JALR: begin
        reg_wr  = f3 == 3'd0;
        is_jalr = f3 == 3'd0;
      end
      OPC_LUI: begin
        reg_wr  = 1'b1;
        imm_fmt = IMM_U;
        a_zero  = 1'b1;
      end
      OPC_AUIPC: begin
        reg_wr  = 1'b1;
        imm_fmt = IMM_U;
        a_pc    = 1'b1;
      end
      default: ;
    endcase
  end
  assign imm   = gen_imm(imm_fmt, inst);
  assign alu_a = a_zero ? 64'd0 : a_pc ? {32'd0, pc_q} : rs1_v;
  assign alu_b = b_imm ? imm : rs2_v;
  always_comb begin
    case (alu_op)
      ALU_SUB:  alu_y = alu_a - alu_b;
      ALU_SLL:  alu_y = alu_a << alu_b[5:0];
      ALU_SLT:  alu_y = {63'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_y = {63'd0, alu_a < alu_b};
      ALU_XOR:  alu_y = alu_a ^ alu_b;
      ALU_SRL:  alu_y = alu_a >> alu_b[5:0];
      ALU_SRA:  alu_y = $signed(alu_a) >>> alu_b[5:0];
      ALU_OR:   alu_y = alu_a | alu_b;
      ALU_AND:  alu_y = alu_a & alu_b;
      default:  alu_y = alu_a + alu_b;
    endcase
  end
  // The address adder is shared by loads, stores and the JALR target.
  assign imm_ls = opcode == OPC_STORE ? {{20{inst[31]}}, inst[31:25], inst[11:7]}
                                      : {{20{inst[31]}}, inst[31:20]};
  assign addr   = rs1_v[31:0] + imm_ls;
  assign size   = f3[1:0];
  assign off    = {addr[2] & (size != 2'd3), addr[1] & ~size[1], addr[0] & (size == 2'd0)};
  assign lsh    = rdata >> {off, 3'b000};
  always_comb begin
    case (f3)
      F3_LB:   load_v = {{56{lsh[7]}}, lsh[7:0]};
      F3_LH:   load_v = {{48{lsh[15]}}, lsh[15:0]};
      F3_LW:   load_v = {{32{lsh[31]}}, lsh[31:0]};
      F3_LBU:  load_v = {56'd0, lsh[7:0]};
      F3_LHU:  load_v = {48'd0, lsh[15:0]};
      F3_LWU:  load_v = {32'd0, lsh[31:0]};
      default: load_v = lsh;
    endcase
  end
  assign mask_raw = size == F3_SB[1:0] ? 8'h01 : size == F3_SH[1:0] ? 8'h03 :
                    size == F3_SW[1:0] ? 8'h0F : 8'hFF;
  assign wdata    = rs2_v << {off, 3'b000};
  assign wr_en    = is_store & ~rst;
  assign wmask    = wr_en ? mask_raw << off : 8'h00;
  assign eq  = rs1_v == rs2_v;
  assign lt  = $signed(rs1_v) < $signed(rs2_v);
  assign ltu = rs1_v < rs2_v;
  assign taken = f3 == F3_BEQ ? eq : f3 == F3_BNE ? ~eq : f3 == F3_BLT ? lt :
                 f3 == F3_BGE ? ~lt : f3 == F3_BLTU ? ltu : ~ltu;
  assign pc_plus4 = pc_q + 32'd4;
  assign wb = (is_jal || is_jalr) ? {32'd0, pc_plus4} : is_load ? load_v : alu_y;
  assign pc_d = is_jal ? pc_q + imm[31:0] :
                is_jalr ? {addr[31:1], 1'b0} :
                (is_branch && taken) ? pc_q + imm[31:0] : pc_plus4;
  always_ff @(posedge clk) pc_q <= rst ? RESET_PC : pc_d;
  assign pc = pc_q;
endmodule

// File: tb/tb_rv64i_single_cycle_core.sv
// tb_rv64i_single_cycle_core: table-driven directed checks plus store/reset sequences for the RV64I core
module tb_rv64i_single_cycle_core;
  logic        clk, rst, init;
  logic [31:0] inst, pc, addr;
  logic        wr_en;
  logic [63:0] wdata, rdata, got, wd;
  logic [7:0]  wmask;
  logic [63:0] mem [256];
  int checks = 0, failures = 0;
  typedef struct {
    logic [31:0] inst;
    logic [4:0]  r;
    logic [63:0] v;
    logic [31:0] npc;
  } vec_t;
  vec_t vt [$];
  localparam logic [6:0] OPI = 7'h13, LDO = 7'h03;
  rv64i_single_cycle_core #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .inst(inst), .pc(pc), .addr(addr),
    .wr_en(wr_en), .wdata(wdata), .wmask(wmask), .rdata(rdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign rdata = mem[addr[10:3]];
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 64'd0;
      mem[0] <= 64'h1122_3344_5566_7788;
      mem[1] <= 64'hFFFF_FFFF_8000_00F0;
    end else if (wr_en) begin
      for (int b = 0; b < 8; b++) if (wmask[b]) mem[addr[10:3]][8*b +: 8] <= wdata[8*b +: 8];
    end
  end
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction
  function automatic vec_t mk(input logic [31:0] i, input logic [4:0] r, input logic [63:0] v,
                              input logic [31:0] p);
    vec_t t;
    t.inst = i; t.r = r; t.v = v; t.npc = p;
    return t;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask
  // A store instruction exposes a register's full value on wdata without a clock edge.
  task automatic peek(input logic [4:0] r, output logic [63:0] v);
    inst = enc_s(12'h400, r, 5'd0, 3'd3);
    #1;
    v = wdata;
  endtask
  task automatic do_store(input logic [31:0] i, input logic [31:0] ea, input logic [7:0] em,
                          output logic [63:0] wd_o);
    inst = i;
    #1;
    chk("st_addr", addr, ea);
    chk("st_mask", wmask, em);
    chk("st_wren", wr_en, 1);
    wd_o = wdata;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog pc=%h", pc);
    $fatal(1, "timeout");
  end
  initial begin
    vt.push_back(mk(enc_i(12'd3, 5'd1, 3'd0, 5'd1, OPI), 5'd1, 64'd3, 32'h4));
    vt.push_back(mk(enc_i(12'hFFF, 5'd1, 3'd0, 5'd1, OPI), 5'd1, 64'd2, 32'h8));
    vt.push_back(mk(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd1), 5'd1, 64'd4, 32'hC));
    vt.push_back(mk(enc_r(7'h20, 5'd1, 5'd1, 3'd0, 5'd1), 5'd1, 64'd0, 32'h10));
    vt.push_back(mk(enc_j(21'h1FFFF4, 5'd2), 5'd2, 64'h14, 32'h4));
    vt.push_back(mk(enc_b(13'h1FFC, 5'd0, 5'd1, 3'd0), 5'd2, 64'h14, 32'h0));
    vt.push_back(mk(enc_b(13'h1FFC, 5'd0, 5'd1, 3'd1), 5'd1, 64'd0, 32'h4));
    vt.push_back(mk(enc_i(12'hFF8, 5'd0, 3'd0, 5'd6, OPI), 5'd6, 64'hFFFF_FFFF_FFFF_FFF8, 32'h8));
    vt.push_back(mk(enc_i(12'h401, 5'd6, 3'd5, 5'd7, OPI), 5'd7, 64'hFFFF_FFFF_FFFF_FFFC, 32'hC));
    vt.push_back(mk(enc_i(12'h03C, 5'd6, 3'd5, 5'd7, OPI), 5'd7, 64'hF, 32'h10));
    vt.push_back(mk(enc_r(7'h00, 5'd0, 5'd6, 3'd2, 5'd8), 5'd8, 64'd1, 32'h14));
    vt.push_back(mk(enc_r(7'h00, 5'd0, 5'd6, 3'd3, 5'd8), 5'd8, 64'd0, 32'h18));
    vt.push_back(mk(enc_i(12'h004, 5'd6, 3'd1, 5'd7, OPI), 5'd7, 64'hFFFF_FFFF_FFFF_FF80, 32'h1C));
    vt.push_back(mk({20'h80000, 5'd10, 7'h37}, 5'd10, 64'hFFFF_FFFF_8000_0000, 32'h20));
    vt.push_back(mk({20'h00001, 5'd11, 7'h17}, 5'd11, 64'h1020, 32'h24));
    vt.push_back(mk(enc_i(12'hFFF, 5'd6, 3'd4, 5'd12, OPI), 5'd12, 64'd7, 32'h28));
    vt.push_back(mk(enc_i(12'h100, 5'd0, 3'd0, 5'd6, OPI), 5'd6, 64'h100, 32'h2C));
    vt.push_back(mk(enc_i(12'h009, 5'd6, 3'd0, 5'd9, 7'h67), 5'd9, 64'h30, 32'h108));
    vt.push_back(mk(enc_i(12'h005, 5'd0, 3'd0, 5'd0, OPI), 5'd0, 64'd0, 32'h10C));
    vt.push_back(mk(32'h0, 5'd9, 64'h30, 32'h110));
    vt.push_back(mk(enc_r(7'h01, 5'd6, 5'd6, 3'd0, 5'd13), 5'd13, 64'd0, 32'h114));
    vt.push_back(mk(enc_i(12'd0, 5'd0, 3'd3, 5'd3, LDO), 5'd3, 64'h1122_3344_5566_7788, 32'h118));
    vt.push_back(mk(enc_i(12'd8, 5'd0, 3'd3, 5'd3, LDO), 5'd3, 64'hFFFF_FFFF_8000_00F0, 32'h11C));
    vt.push_back(mk(enc_i(12'd8, 5'd0, 3'd2, 5'd4, LDO), 5'd4, 64'hFFFF_FFFF_8000_00F0, 32'h120));
    vt.push_back(mk(enc_i(12'd8, 5'd0, 3'd6, 5'd4, LDO), 5'd4, 64'h0000_0000_8000_00F0, 32'h124));
    vt.push_back(mk(enc_i(12'd8, 5'd0, 3'd4, 5'd5, LDO), 5'd5, 64'hF0, 32'h128));
    vt.push_back(mk(enc_i(12'd8, 5'd0, 3'd0, 5'd5, LDO), 5'd5, 64'hFFFF_FFFF_FFFF_FFF0, 32'h12C));
    vt.push_back(mk(enc_i(12'd11, 5'd0, 3'd1, 5'd5, LDO), 5'd5, 64'hFFFF_FFFF_FFFF_8000, 32'h130));
    vt.push_back(mk(enc_i(12'd11, 5'd0, 3'd4, 5'd5, LDO), 5'd5, 64'h80, 32'h134));
    vt.push_back(mk(enc_i(12'd0, 5'd0, 3'd3, 5'd3, LDO), 5'd3, 64'h1122_3344_5566_7788, 32'h138));
    rst = 1'b1; inst = 32'h0; init = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    init = 1'b0;
    chk("reset_pc", pc, 0);
    chk("reset_wren", wr_en, 0);
    rst = 1'b0;
    for (int k = 0; k < vt.size(); k++) begin
      inst = vt[k].inst;
      #1;
      chk($sformatf("vec%0d_wren", k), wr_en, 0);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pc", k), pc, vt[k].npc);
      peek(vt[k].r, got);
      chk($sformatf("vec%0d_x%0d", k, vt[k].r), got, vt[k].v);
    end
    do_store(enc_s(12'd32, 5'd3, 5'd0, 3'd3), 32'h20, 8'hFF, wd);
    chk("sd_mem4", mem[4], 64'h1122_3344_5566_7788);
    do_store(enc_s(12'd40, 5'd0, 5'd0, 3'd3), 32'h28, 8'hFF, wd);
    do_store(enc_s(12'd40, 5'd3, 5'd0, 3'd2), 32'h28, 8'h0F, wd);
    chk("sw_mem5", mem[5], 64'h0000_0000_5566_7788);
    do_store(enc_s(12'd48, 5'd0, 5'd0, 3'd3), 32'h30, 8'hFF, wd);
    do_store(enc_s(12'd48, 5'd3, 5'd0, 3'd1), 32'h30, 8'h03, wd);
    chk("sh_mem6", mem[6], 64'h7788);
    do_store(enc_s(12'd51, 5'd3, 5'd0, 3'd0), 32'h33, 8'h08, wd);
    chk("sb_lane", wd[31:24], 64'h88);
    chk("sb_mem6", mem[6], 64'h8800_7788);
    do_store(enc_s(12'd44, 5'd3, 5'd0, 3'd2), 32'h2C, 8'hF0, wd);
    chk("sw_hi_mem5", mem[5], 64'h5566_7788_5566_7788);
    chk("store_pc", pc, 32'h154);
    peek(5'd12, got);
    chk("store_no_rd", got, 64'd7);
    inst = enc_s(12'd56, 5'd3, 5'd0, 3'd3);
    rst = 1'b1;
    #1;
    chk("rst_wren", wr_en, 0);
    chk("rst_wmask", wmask, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_pc", pc, 0);
    chk("rst_mem7", mem[7], 64'd0);
    peek(5'd3, got);
    chk("rst_x3", got, 64'd0);
    peek(5'd12, got);
    chk("rst_x12", got, 64'd0);
    inst = 32'h0;
    #1;
    chk("nop_wren", wr_en, 0);
    @(posedge clk);
    #1;
    chk("nop_pc", pc, 32'h4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
